// File: rtl/timelock_host_if.sv
// Byte link between the timelock host sequencer and its UART transmitter/receiver.
// master = host sequencer side, slave = transmitter/receiver side.
interface timelock_host_if;
   logic       tx_new_byte;
   logic [7:0] tx_byte;
   logic       tx_ready;
   logic       rx_new_byte;
   logic [7:0] rx_byte;

   modport master (
      output tx_new_byte,
      output tx_byte,
      input  tx_ready,
      input  rx_new_byte,
      input  rx_byte
   );

   modport slave (
      input  tx_new_byte,
      input  tx_byte,
      output tx_ready,
      output rx_new_byte,
      output rx_byte
   );
endinterface

// File: rtl/timelock_host.sv
// Host-side LOAD/COMPUTE/READ nibble-command sequencer for the timelock UART protocol.
// Optional reply watchdog enabled by defining TIMELOCK_HOST_TIMEOUT_EN.
module timelock_host #(
   parameter int unsigned NIBBLES        = 92,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   operand,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [4*NIBBLES-1:0]   result,
   timelock_host_if.master        link
);

   localparam int unsigned W  = 4 * NIBBLES;
   localparam int unsigned IW = 7;

   localparam logic [3:0] CODE_LOAD       = 4'h0;
   localparam logic [3:0] CODE_ACKLOAD    = 4'h1;
   localparam logic [3:0] CODE_COMPUTE    = 4'h2;
   localparam logic [3:0] CODE_ACKCOMPUTE = 4'h3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEND,
      S_WAIT_ACK,
      S_FINISH
   } state_t;

   typedef enum logic [1:0] {
      PH_LOAD,
      PH_COMPUTE,
      PH_READ
   } phase_t;

   state_t          state;
   phase_t          phase;
   logic [IW-1:0]   idx;
   logic [W-1:0]    op_q;
   logic [W-5:0]    res_sr;
   logic            last_idx_c;
   logic            reply_ok_c;
   logic [7:0]      tx_byte_c;
   logic [W-1:0]    shifted_c;

`ifdef TIMELOCK_HOST_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0]   tmo_cnt;
`else
   logic [31:0]     unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   assign last_idx_c = (idx == IW'(NIBBLES - 1));
   // Result nibbles arrive LSB first and are shifted in from the top.
   assign shifted_c  = {link.rx_byte[7:4], res_sr};

   // Outgoing command byte and reply acceptance for the current phase.
   always_comb begin
      tx_byte_c  = 8'h00;
      reply_ok_c = 1'b0;
      case (phase)
         PH_LOAD: begin
            tx_byte_c  = {op_q[{idx, 2'b00} +: 4], CODE_LOAD};
            reply_ok_c = (link.rx_byte[3:0] == CODE_ACKLOAD);
         end
         PH_COMPUTE: begin
            tx_byte_c  = {4'h0, CODE_COMPUTE};
            reply_ok_c = (link.rx_byte == {4'h0, CODE_ACKCOMPUTE});
         end
         PH_READ: begin
            tx_byte_c  = {4'h0, CODE_LOAD};
            reply_ok_c = (link.rx_byte[3:0] == CODE_ACKLOAD);
         end
         default: begin
            tx_byte_c  = 8'h00;
            reply_ok_c = 1'b0;
         end
      endcase
   end

   // Sequencer state, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         phase            <= PH_LOAD;
         idx              <= '0;
         op_q             <= '0;
         res_sr           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         result           <= '0;
         link.tx_new_byte <= 1'b0;
         link.tx_byte     <= 8'h00;
`ifdef TIMELOCK_HOST_TIMEOUT_EN
         tmo_cnt          <= '0;
`endif
      end else begin
         done             <= 1'b0;
         error            <= 1'b0;
         link.tx_new_byte <= 1'b0;
         case (state)
            S_IDLE, S_FINISH: begin
               state <= S_IDLE;
               if (start) begin
                  op_q  <= operand;
                  phase <= PH_LOAD;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= S_SEND;
               end
            end
            S_SEND: begin
               if (link.tx_ready) begin
                  link.tx_new_byte <= 1'b1;
                  link.tx_byte     <= tx_byte_c;
                  state            <= S_WAIT_ACK;
`ifdef TIMELOCK_HOST_TIMEOUT_EN
                  tmo_cnt          <= '0;
`endif
               end
            end
            S_WAIT_ACK: begin
               if (link.rx_new_byte) begin
                  if (!reply_ok_c) begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     state <= S_SEND;
                     case (phase)
                        PH_LOAD: begin
                           if (last_idx_c) begin
                              phase <= PH_COMPUTE;
                              idx   <= '0;
                           end else begin
                              idx <= idx + IW'(1);
                           end
                        end
                        PH_COMPUTE: begin
                           phase <= PH_READ;
                           idx   <= '0;
                        end
                        PH_READ: begin
                           res_sr <= shifted_c[W-1:4];
                           if (last_idx_c) begin
                              result <= shifted_c;
                              done   <= 1'b1;
                              busy   <= 1'b0;
                              idx    <= '0;
                              state  <= S_FINISH;
                           end else begin
                              idx <= idx + IW'(1);
                           end
                        end
                        default: state <= S_IDLE;
                     endcase
                  end
               end
`ifdef TIMELOCK_HOST_TIMEOUT_EN
               else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timelock_host.sv
// Self-checking bench for timelock_host against a behavioural remote controller (y = x + 1).
module tb_timelock_host;
   localparam int unsigned NIB = 92;
   localparam int unsigned W   = 4 * NIB;
   localparam int unsigned TMO = 100;
   localparam int unsigned TOTAL_BYTES = 2 * NIB + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] operand;
   logic         busy, done, error;
   logic [W-1:0] result;

   timelock_host_if link ();

   timelock_host #(.NIBBLES(NIB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .operand (operand),
      .busy    (busy),
      .done    (done),
      .error   (error),
      .result  (result),
      .link    (link)
   );

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Remote-side observation and model state (written only by the remote process).
   logic [7:0]   sent_q[$];
   longint       sent_cyc[$];
   int           n_done = 0;
   int           n_err  = 0;
   int           read_cnt;
   // Modes set by the main sequence.
   bit           bad_first    = 1'b0;
   bit           mute_compute = 1'b0;
   bit           spur_en      = 1'b0;

   // Behavioural remote controller: collects LOAD nibbles, computes x+1, serves READs.
   initial begin : remote
      logic [W-1:0] x_val, y_val;
      logic [7:0]   b, rep;
      int           load_cnt, dly;
      bit           computed, pend, spur_next;
      link.rx_new_byte = 1'b0;
      link.rx_byte     = 8'h00;
      x_val = '0; y_val = '0; rep = 8'h00;
      load_cnt = 0; read_cnt = 0; dly = 0;
      computed = 1'b0; pend = 1'b0; spur_next = 1'b0;
      forever begin
         @(negedge clk);
         link.rx_new_byte = 1'b0;
         if (!rst_n) begin
            pend = 1'b0; spur_next = 1'b0;
            load_cnt = 0; read_cnt = 0; computed = 1'b0;
         end else begin
            if (start && !busy) begin
               load_cnt = 0; read_cnt = 0; computed = 1'b0; x_val = '0;
            end
            if (done)  n_done++;
            if (error) n_err++;
            if (link.tx_new_byte) begin
               b = link.tx_byte;
               sent_q.push_back(b);
               sent_cyc.push_back(cyc);
               pend = 1'b1;
               dly  = $urandom_range(0, 4);
               if (!computed && load_cnt < NIB && b[3:0] == 4'h0) begin
                  x_val[4*load_cnt +: 4] = b[7:4];
                  rep = {4'($urandom), 4'h1};
                  if (bad_first && load_cnt == 0) rep = 8'h05;
                  load_cnt++;
               end else if (b == 8'h02) begin
                  y_val    = x_val + W'(1);
                  computed = 1'b1;
                  rep      = 8'h03;
                  if (mute_compute) pend = 1'b0;
               end else if (computed && b == 8'h00 && read_cnt < NIB) begin
                  rep = {y_val[4*read_cnt +: 4], 4'h1};
                  read_cnt++;
               end else begin
                  pend = 1'b0;
               end
            end else if (pend) begin
               if (dly == 0) begin
                  link.rx_byte     = rep;
                  link.rx_new_byte = 1'b1;
                  pend             = 1'b0;
                  spur_next        = spur_en;
               end else begin
                  dly--;
               end
            end else if (spur_next) begin
               // Lands while the host is back in SEND, so it must be dropped.
               link.rx_byte     = 8'h05;
               link.rx_new_byte = 1'b1;
               spur_next        = 1'b0;
            end
         end
      end
   end

   // Transmitter model: occasionally busy for a few cycles after each byte.
   initial begin : transmitter
      int cnt;
      cnt = 0;
      link.tx_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            link.tx_ready = 1'b1;
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) link.tx_ready = 1'b1;
         end else if (link.tx_new_byte && $urandom_range(0, 1) == 1) begin
            link.tx_ready = 1'b0;
            cnt = $urandom_range(1, 3);
         end
      end
   end

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < 11; i++) v[32*i +: 32] = $urandom;
      v[W-1:352] = 16'($urandom);
      return v;
   endfunction

   task automatic pulse_start(input logic [W-1:0] op);
      @(posedge clk); #1;
      start   = 1'b1;
      operand = op;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic wait_end(input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (done || error) got = 1'b1;
      end
   endtask

   task automatic wait_sent(input int target, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (sent_q.size() >= target) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      bit saw_tx;
      saw_tx  = 1'b0;
      rst_n   = 1'b0;
      start   = 1'b1;
      operand = rand_op();
      repeat (6) begin
         @(negedge clk);
         if (link.tx_new_byte) saw_tx = 1'b1;
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
      checks++; if (link.tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte: got %h want 00", link.tx_byte); end
      checks++; if (saw_tx !== 1'b0) begin errors++; $display("FAIL reset_tx_new_byte: got pulse want none"); end
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_load_order();
      logic [W-1:0] op;
      logic [7:0]   exp_b;
      int           base, d0;
      bit           got;
      op   = {304'h0, 64'hFEDCBA9876543210};
      base = sent_q.size();
      d0   = n_done;
      pulse_start(op);
      wait_end(6000, got);
      repeat (3) @(negedge clk);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL load_order_end: got no done/error want completion"); end
      checks++;
      if (sent_q.size() - base != TOTAL_BYTES) begin
         errors++; $display("FAIL load_order_count: got %0d bytes want %0d", sent_q.size() - base, TOTAL_BYTES);
      end else begin
         for (int i = 0; i < TOTAL_BYTES; i++) begin
            if (i < 16)       exp_b = {4'(i), 4'h0};
            else if (i < NIB) exp_b = 8'h00;
            else if (i == NIB) exp_b = 8'h02;
            else              exp_b = 8'h00;
            checks++;
            if (sent_q[base + i] !== exp_b) begin
               errors++; $display("FAIL load_order_byte%0d: got %h want %h", i, sent_q[base + i], exp_b);
            end
         end
      end
      checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL load_order_done: got %0d pulses want 1", n_done - d0); end
      checks++; if (result !== op + W'(1)) begin errors++; $display("FAIL load_order_result: got %h want %h", result, op + W'(1)); end
   endtask

   task automatic test_full_transaction(input logic [W-1:0] op, input string tag);
      int  base, d0, e0;
      bit  got;
      base = sent_q.size();
      d0   = n_done;
      e0   = n_err;
      pulse_start(op);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_high: got %b want 1", tag, busy); end
      wait_end(6000, got);
      repeat (3) @(negedge clk);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL %s_end: got no done/error want completion", tag); end
      checks++; if (sent_q.size() - base != TOTAL_BYTES) begin errors++; $display("FAIL %s_count: got %0d want %0d", tag, sent_q.size() - base, TOTAL_BYTES); end
      checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL %s_done: got %0d want 1", tag, n_done - d0); end
      checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL %s_error: got %0d want 0", tag, n_err - e0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_low: got %b want 0", tag, busy); end
      checks++; if (result !== op + W'(1)) begin errors++; $display("FAIL %s_result: got %h want %h", tag, result, op + W'(1)); end
   endtask

   task automatic test_bad_reply();
      int  base, d0, e0;
      bit  got;
      bad_first = 1'b1;
      base = sent_q.size();
      d0   = n_done;
      e0   = n_err;
      pulse_start(rand_op());
      wait_end(200, got);
      bad_first = 1'b0;
      repeat (50) @(negedge clk);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL bad_reply_end: got no error want error"); end
      checks++; if (n_err - e0 != 1) begin errors++; $display("FAIL bad_reply_error: got %0d pulses want 1", n_err - e0); end
      checks++; if (n_done - d0 != 0) begin errors++; $display("FAIL bad_reply_done: got %0d pulses want 0", n_done - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bad_reply_busy: got %b want 0", busy); end
      checks++; if (sent_q.size() - base != 1) begin errors++; $display("FAIL bad_reply_tx: got %0d bytes want 1", sent_q.size() - base); end
      test_full_transaction(W'(5), "after_bad");
   endtask

   task automatic test_ignore();
      int  base, d0, e0;
      bit  got, got_s;
      spur_en = 1'b1;
      base = sent_q.size();
      d0   = n_done;
      e0   = n_err;
      pulse_start(W'(5));
      wait_sent(base + NIB + 10, 4000, got_s);
      pulse_start(rand_op());
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy: got %b want 1", busy); end
      wait_end(6000, got);
      spur_en = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (got_s !== 1'b1 || got !== 1'b1) begin errors++; $display("FAIL ignore_end: got %b/%b want 1/1", got_s, got); end
      checks++; if (sent_q.size() - base != TOTAL_BYTES) begin errors++; $display("FAIL ignore_count: got %0d want %0d", sent_q.size() - base, TOTAL_BYTES); end
      checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL ignore_done: got %0d want 1", n_done - d0); end
      checks++; if (n_err - e0 != 0) begin errors++; $display("FAIL ignore_error: got %0d want 0", n_err - e0); end
      checks++; if (result !== W'(6)) begin errors++; $display("FAIL ignore_result: got %h want 6", result); end
   endtask

   task automatic test_timeout();
      int     base, e0;
      longint entry, hit;
      bit     got, saw_err;
      mute_compute = 1'b1;
      base = sent_q.size();
      e0   = n_err;
      pulse_start(rand_op());
      wait_sent(base + NIB + 1, 4000, got);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL timeout_reach_compute: got %0d bytes want %0d", sent_q.size() - base, NIB + 1); end
      entry = got ? sent_cyc[base + NIB] : 0;
`ifdef TIMELOCK_HOST_TIMEOUT_EN
      hit = 0;
      saw_err = 1'b0;
      for (int i = 0; i < 400 && !saw_err; i++) begin
         @(negedge clk);
         if (error) begin saw_err = 1'b1; hit = cyc; end
      end
      checks++; if (saw_err !== 1'b1) begin errors++; $display("FAIL timeout_error: got none want pulse"); end
      checks++; if (hit - entry != TMO) begin errors++; $display("FAIL timeout_latency: got %0d cycles want %0d", hit - entry, TMO); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", busy); end
`else
      hit = entry;
      saw_err = 1'b0;
      repeat (10_000) begin
         @(negedge clk);
         if (error) saw_err = 1'b1;
      end
      checks++; if (saw_err !== 1'b0) begin errors++; $display("FAIL timeout_disabled_error: got pulse want none"); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_disabled_busy: got %b want 1", busy); end
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
`endif
      mute_compute = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset_abort();
      int  base, d0, e0;
      bit  got, saw_tx;
      base = sent_q.size();
      pulse_start(rand_op());
      wait_sent(base + 30, 2000, got);
      @(negedge clk);
      d0 = n_done;
      e0 = n_err;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || link.tx_new_byte !== 1'b0) begin errors++; $display("FAIL abort_outputs: got busy=%b tx=%b want 0/0", busy, link.tx_new_byte); end
      checks++; if (result !== '0) begin errors++; $display("FAIL abort_result: got %h want 0", result); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      saw_tx = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (link.tx_new_byte) saw_tx = 1'b1;
      end
      checks++; if (got !== 1'b1 || n_done != d0 || n_err != e0) begin errors++; $display("FAIL abort_pulses: got done=%0d err=%0d want 0/0", n_done - d0, n_err - e0); end
      checks++; if (saw_tx !== 1'b0) begin errors++; $display("FAIL abort_idle_tx: got pulse want none"); end
      test_full_transaction(rand_op(), "after_abort");
   endtask

   initial begin : main
      rst_n   = 1'b0;
      start   = 1'b0;
      operand = '0;
      test_reset();
      test_load_order();
      test_full_transaction(W'(5), "plus_one");
      test_full_transaction(rand_op(), "random_a");
      test_full_transaction(rand_op(), "random_b");
      test_full_transaction({W{1'b1}}, "all_ones");
      test_bad_reply();
      test_ignore();
      test_timeout();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timelock_host.md
# timelock_host

Host-side command sequencer for the timelock UART protocol: drives a byte transmitter and consumes a byte receiver to load a 368-bit operand into a remote timelock controller, trigger computation, and read the 368-bit result back. It is the initiator for the LOAD/COMPUTE nibble-command protocol. A local agent presents `operand`, pulses `start`, and gets `result` with a `done` pulse.

## Interface

- `NIBBLES`, default 92: operand/result nibble count (368 bits / 4).
- `TIMEOUT_CYCLES`, default 1_000_000: reply watchdog limit; used only with `TIMELOCK_HOST_TIMEOUT_EN`.

- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only when `busy`=0.
- `operand`  in  368  `[183:0]` = xs, `[367:184]` = xc; captured on accepted `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`/`error`.
- `done`  out  1  one-cycle pulse; `result` valid from this cycle.
- `error`  out  1  one-cycle pulse: bad reply code, or timeout.
- `result`  out  368  `[183:0]` = ys, `[367:184]` = yc; held until next completion.
- `tx_new_byte`  out  1  one-cycle pulse: send `tx_byte`.
- `tx_byte`  out  8  byte to transmitter; stable while `tx_new_byte` high.
- `tx_ready`  in  1  transmitter idle.
- `rx_new_byte`  in  1  one-cycle pulse: `rx_byte` valid.
- `rx_byte`  in  8  received byte.

## Operation

- Command byte = `{data[3:0], code[3:0]}`. Codes: LOAD=0, ACKLOAD=1, COMPUTE=2, ACKCOMPUTE=3.
- Phases, counter `idx` (7 bits) over 0..NIBBLES-1:
  - LOAD: send `{op[4*idx+3:4*idx], 4'h0}`, nibble 0 first; expect reply low nibble 1; reply high nibble discarded.
  - COMPUTE: send `8'h02`; expect reply exactly `8'h03` (any delay).
  - READ: send `8'h00` NIBBLES times; each reply must have low nibble 1; `res <= {rx_byte[7:4], res[367:4]}`. After NIBBLES replies `res` equals remote y.
- States: IDLE -> SEND -> WAIT_ACK -> (SEND next | next phase SEND | FINISH) -> IDLE.
  - IDLE: `start` latches `operand`, phase=LOAD, idx=0.
  - SEND: wait for `tx_ready`=1; pulse `tx_new_byte` one cycle; go WAIT_ACK.
  - WAIT_ACK: on `rx_new_byte`, check code; good -> advance idx/phase; bad -> pulse `error`, IDLE.
  - FINISH: copy shift register to `result`, pulse `done`, IDLE.
- `rx_new_byte` outside WAIT_ACK is ignored (dropped, no error).
- `start` while `busy`=1 ignored.
- Exactly 2*NIBBLES+1 bytes transmitted per successful transaction.

## Timing

- Reset values: `busy`=0, `done`=0, `error`=0, `result`=0, `tx_new_byte`=0, `tx_byte`=0, state IDLE, idx=0.
- Reset asserted mid-transaction: immediate abort to reset values; no `done`/`error`.
- `tx_new_byte` rises the cycle after SEND sees `tx_ready`=1; never two pulses without an intervening accepted reply.
- Reply accepted in the same cycle `rx_new_byte`=1; next SEND entered the following cycle.
- `done`/`error` asserted the cycle after the final/bad reply; `busy` falls in the same cycle.
- idx wraps to 0 at phase change; never exceeds NIBBLES-1.

## Configuration

- `TIMELOCK_HOST_TIMEOUT_EN` defined: cycle counter cleared on entering WAIT_ACK; reaching `TIMEOUT_CYCLES` without a reply pulses `error` and returns to IDLE. Applies to all phases including COMPUTE wait.
- Undefined: no counter; WAIT_ACK waits indefinitely.

## Test plan

- Reset: hold `rst_n`=0 with `tx_ready`=1, `start`=1 -> all outputs 0, no `tx_new_byte`.
- Load order: `operand`=368'h0...0FEDCBA9876543210 -> bytes 0x00,0x10,0x20,...,0xF0, then 0x00 x76, then 0x02.
- Full transaction with behavioural controller computing y = x + 1, operand=368'h5 -> 185 bytes sent, `done` once, `result`=368'h6, `busy` low afterwards.
- Bad reply: answer first LOAD with 0x05 -> `error` pulse, `busy`=0, no further `tx_new_byte`; subsequent `start` runs normally.
- `start` re-pulsed during READ and spurious `rx_new_byte` in SEND -> ignored, result unchanged from case 3.
- Macro on, TIMEOUT_CYCLES=100, no reply to COMPUTE -> `error` exactly 100 cycles after WAIT_ACK entry; macro off -> no `error` after 10_000 cycles.
